// File: rtl/cache_pkg.sv
// cache_pkg: shared types and helpers for the 2-way set-associative cache.
//  - cache_state_t : controller states (IDLE, FILL, FLUSH)
//  - clog2         : constant-foldable ceiling log2, used for field widths
//  - wordOf/indexOf/tagOf : slice a byte address into word offset, set index
//                    and tag. Bit 0 is the byte-in-word bit and is ignored.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    FLUSH = 2'd2
  } cache_state_t;

  function automatic int clog2(input int value);
    int width;
    width = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) width = i + 1;
    end
    return width;
  endfunction

  function automatic logic [31:0] wordOf(input logic [31:0] addr, input int offW);
    return (addr >> 1) & ((32'd1 << offW) - 32'd1);
  endfunction

  function automatic logic [31:0] indexOf(input logic [31:0] addr, input int offW, input int idxW);
    return (addr >> (offW + 1)) & ((32'd1 << idxW) - 32'd1);
  endfunction

  function automatic logic [31:0] tagOf(input logic [31:0] addr, input int offW, input int idxW);
    return addr >> (offW + idxW + 1);
  endfunction

endpackage

// File: rtl/cache_way_array.sv
// cache_way_array: storage for one way of the cache.
//  - SETS x WORDS data RAM: asynchronous read, synchronous single-word write.
//  - SETS tag RAM plus a valid vector: synchronous write; the valid vector
//    is cleared by reset (active-low, synchronous) and by i_clearAll.
// Ports:
//  i_clk, i_rst      clock and synchronous active-low reset
//  i_clearAll        invalidate every line of this way
//  i_rdIdx/i_rdWord  lookup address; o_rdData/o_rdTag/o_rdValid follow it combinationally
//  i_dataWe          write i_wrData into word i_wrWord of set i_wrIdx
//  i_tagWe           write i_wrTag into set i_wrIdx and mark it valid
import cache_pkg::*;

module cache_way_array #(
  parameter int SETS   = 64,
  parameter int WORDS  = 8,
  parameter int DATA_W = 16,
  parameter int TAG_W  = 6,
  parameter int IDX_W  = 6,
  parameter int OFF_W  = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clearAll,
  input  logic [IDX_W-1:0]  i_rdIdx,
  input  logic [OFF_W-1:0]  i_rdWord,
  output logic [DATA_W-1:0] o_rdData,
  output logic [TAG_W-1:0]  o_rdTag,
  output logic              o_rdValid,
  input  logic              i_dataWe,
  input  logic              i_tagWe,
  input  logic [IDX_W-1:0]  i_wrIdx,
  input  logic [OFF_W-1:0]  i_wrWord,
  input  logic [DATA_W-1:0] i_wrData,
  input  logic [TAG_W-1:0]  i_wrTag
);

  logic [DATA_W-1:0] r_data [SETS][WORDS];
  logic [TAG_W-1:0]  r_tag  [SETS];
  logic [SETS-1:0]   r_valid;

  assign o_rdData  = r_data[i_rdIdx][i_rdWord];
  assign o_rdTag   = r_tag[i_rdIdx];
  assign o_rdValid = r_valid[i_rdIdx];

  // Data and tag contents are deliberately left unreset; only the valid
  // vector decides whether they mean anything.
  always_ff @(posedge i_clk) begin
    if (i_dataWe) r_data[i_wrIdx][i_wrWord] <= i_wrData;
  end

  always_ff @(posedge i_clk) begin
    if (i_tagWe) r_tag[i_wrIdx] <= i_wrTag;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_valid <= '0;
    end else if (i_clearAll) begin
      r_valid <= '0;
    end else if (i_tagWe) begin
      r_valid[i_wrIdx] <= 1'b1;
    end
  end

endmodule

// File: rtl/assoc_cache.sv
// assoc_cache: 2-way set-associative, write-through, no-write-allocate cache
// with per-set LRU replacement, sitting between a pipeline stage and the
// memory arbiter. Read misses fill a whole block from a pipelined memory whose
// returns come back in issue order.
// Ports:
//  i_clk, i_rst                 clock, synchronous active-low reset
//  i_pipe_rd, i_pipe_wr         held requests (rd and wr together = write)
//  i_pipe_addr, i_pipe_wdata    request byte address and write data
//  i_flush                      one-cycle pulse, invalidate all lines
//  o_pipe_rdata, o_pipe_done    read data / request completes this cycle
//  o_stall                      request present but not completing
//  o_mem_rd, o_mem_wr           memory read issue / write-through
//  o_mem_addr, o_mem_wdata      memory byte address / write data
//  i_mem_rvalid, i_mem_rdata    in-order memory read returns
import cache_pkg::*;

module assoc_cache #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int SETS   = 64,
  parameter int WORDS  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_pipe_rd,
  input  logic              i_pipe_wr,
  input  logic [ADDR_W-1:0] i_pipe_addr,
  input  logic [DATA_W-1:0] i_pipe_wdata,
  input  logic              i_flush,
  output logic [DATA_W-1:0] o_pipe_rdata,
  output logic              o_pipe_done,
  output logic              o_stall,
  output logic              o_mem_rd,
  output logic              o_mem_wr,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_rvalid,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam int OFF_W = clog2(WORDS);
  localparam int IDX_W = clog2(SETS);
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W - 1;

  cache_state_t r_state, w_nextState;

  logic [OFF_W:0]   r_issCnt;
  logic [OFF_W-1:0] r_retCnt;
  logic             r_flushPend;
  logic [SETS-1:0]  r_lru;
  logic             r_victim;
  logic [IDX_W-1:0] r_fillIdx;
  logic [TAG_W-1:0] r_fillTag;

  logic [OFF_W-1:0]  w_word;
  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic [DATA_W-1:0] w_data0, w_data1;
  logic [TAG_W-1:0]  w_tag0, w_tag1;
  logic              w_valid0, w_valid1;
  logic              w_hit0, w_hit1, w_hit;
  logic              w_victim;

  logic              w_we0, w_we1, w_tagWe0, w_tagWe1, w_clearAll;
  logic [IDX_W-1:0]  w_wrIdx;
  logic [OFF_W-1:0]  w_wrWord;
  logic [DATA_W-1:0] w_wrData;
  logic              w_lruWe, w_lruVal;
  logic [IDX_W-1:0]  w_lruIdx;
  logic              w_startFill;

  assign w_word = OFF_W'(wordOf(32'(i_pipe_addr), OFF_W));
  assign w_idx  = IDX_W'(indexOf(32'(i_pipe_addr), OFF_W, IDX_W));
  assign w_tag  = TAG_W'(tagOf(32'(i_pipe_addr), OFF_W, IDX_W));

  cache_way_array #(
    .SETS(SETS), .WORDS(WORDS), .DATA_W(DATA_W),
    .TAG_W(TAG_W), .IDX_W(IDX_W), .OFF_W(OFF_W)
  ) way0 (
    .i_clk(i_clk), .i_rst(i_rst), .i_clearAll(w_clearAll),
    .i_rdIdx(w_idx), .i_rdWord(w_word),
    .o_rdData(w_data0), .o_rdTag(w_tag0), .o_rdValid(w_valid0),
    .i_dataWe(w_we0), .i_tagWe(w_tagWe0),
    .i_wrIdx(w_wrIdx), .i_wrWord(w_wrWord), .i_wrData(w_wrData), .i_wrTag(r_fillTag)
  );

  cache_way_array #(
    .SETS(SETS), .WORDS(WORDS), .DATA_W(DATA_W),
    .TAG_W(TAG_W), .IDX_W(IDX_W), .OFF_W(OFF_W)
  ) way1 (
    .i_clk(i_clk), .i_rst(i_rst), .i_clearAll(w_clearAll),
    .i_rdIdx(w_idx), .i_rdWord(w_word),
    .o_rdData(w_data1), .o_rdTag(w_tag1), .o_rdValid(w_valid1),
    .i_dataWe(w_we1), .i_tagWe(w_tagWe1),
    .i_wrIdx(w_wrIdx), .i_wrWord(w_wrWord), .i_wrData(w_wrData), .i_wrTag(r_fillTag)
  );

  assign w_hit0 = w_valid0 && (w_tag0 == w_tag);
  assign w_hit1 = w_valid1 && (w_tag1 == w_tag);
  assign w_hit  = w_hit0 | w_hit1;

  // Empty ways are filled before anything valid is evicted; way0 first.
  assign w_victim = !w_valid0 ? 1'b0 : (!w_valid1 ? 1'b1 : r_lru[w_idx]);

  assign o_pipe_rdata = w_hit1 ? w_data1 : w_data0;
  assign o_mem_wdata  = i_pipe_wdata;
  assign o_stall      = (i_pipe_rd | i_pipe_wr) & ~o_pipe_done;

  // Everything is gated by reset so the memory and pipeline handshakes read
  // idle while reset is held, whatever state the registers are in.
  // An LRU bit names the way to replace next, so touching a way stores the other.
  always_comb begin
    w_nextState = r_state;
    o_pipe_done = 1'b0;
    o_mem_rd    = 1'b0;
    o_mem_wr    = 1'b0;
    o_mem_addr  = i_pipe_addr;
    w_we0       = 1'b0;
    w_we1       = 1'b0;
    w_tagWe0    = 1'b0;
    w_tagWe1    = 1'b0;
    w_clearAll  = 1'b0;
    w_wrIdx     = w_idx;
    w_wrWord    = w_word;
    w_wrData    = i_pipe_wdata;
    w_lruWe     = 1'b0;
    w_lruIdx    = w_idx;
    w_lruVal    = 1'b0;
    w_startFill = 1'b0;
    if (i_rst) begin
      case (r_state)
        IDLE: begin
          if (i_flush) begin
            w_nextState = FLUSH;
          end else if (i_pipe_wr) begin
            o_pipe_done = 1'b1;
            o_mem_wr    = 1'b1;
            if (w_hit) begin
              w_we0    = w_hit0;
              w_we1    = w_hit1;
              w_lruWe  = 1'b1;
              w_lruVal = w_hit0;
            end
          end else if (i_pipe_rd) begin
            if (w_hit) begin
              o_pipe_done = 1'b1;
              w_lruWe     = 1'b1;
              w_lruVal    = w_hit0;
            end else begin
              w_startFill = 1'b1;
              w_nextState = FILL;
            end
          end
        end
        FILL: begin
          o_mem_rd   = ~r_issCnt[OFF_W];
          o_mem_addr = {r_fillTag, r_fillIdx, r_issCnt[OFF_W-1:0], 1'b0};
          w_wrIdx    = r_fillIdx;
          w_wrWord   = r_retCnt;
          w_wrData   = i_mem_rdata;
          if (i_mem_rvalid) begin
            w_we0 = ~r_victim;
            w_we1 = r_victim;
            if (r_retCnt == OFF_W'(WORDS - 1)) begin
              w_tagWe0    = ~r_victim;
              w_tagWe1    = r_victim;
              w_lruWe     = 1'b1;
              w_lruIdx    = r_fillIdx;
              w_lruVal    = ~r_victim;
              w_nextState = (r_flushPend | i_flush) ? FLUSH : IDLE;
            end
          end
        end
        FLUSH: begin
          w_clearAll  = 1'b1;
          w_nextState = IDLE;
        end
        default: w_nextState = IDLE;
      endcase
    end
  end

  // Fill bookkeeping is captured on the miss cycle; the block base is the
  // stored tag and index with a zero word offset.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state     <= IDLE;
      r_issCnt    <= '0;
      r_retCnt    <= '0;
      r_flushPend <= 1'b0;
      r_lru       <= '0;
      r_victim    <= 1'b0;
      r_fillIdx   <= '0;
      r_fillTag   <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_startFill) begin
        r_issCnt  <= '0;
        r_retCnt  <= '0;
        r_victim  <= w_victim;
        r_fillIdx <= w_idx;
        r_fillTag <= w_tag;
      end else if (r_state == FILL) begin
        if (o_mem_rd) r_issCnt <= r_issCnt + (OFF_W + 1)'(1);
        if (i_mem_rvalid) r_retCnt <= r_retCnt + OFF_W'(1);
      end
      if (r_state == FILL && i_flush) begin
        r_flushPend <= 1'b1;
      end else if (r_state == FLUSH) begin
        r_flushPend <= 1'b0;
      end
      if (w_clearAll) begin
        r_lru <= '0;
      end else if (w_lruWe) begin
        r_lru[w_lruIdx] <= w_lruVal;
      end
    end
  end

endmodule
